// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of the two producer handshakes and the register-file
// write port served by wb_arbiter.
//   alu_valid/alu_ready/alu_waddr/alu_wdata : single-cycle ALU result
//   ld_valid/ld_ready/ld_waddr/ld_wdata     : variable-latency load result
//   we/waddr/wdata                          : register-file write port
// Modports: master = the producers and the register file; slave = the arbiter.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output ld_valid, ld_waddr, ld_wdata,
        input  alu_ready, ld_ready,
        input  we, waddr, wdata
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  ld_valid, ld_waddr, ld_wdata,
        output alu_ready, ld_ready,
        output we, waddr, wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: drives the register file's single write port from the ALU
// result path and the load result path. ALU results normally win; loads wait
// in a small FIFO and a saturating starvation counter forces a load slot after
// STARVE_MAX consecutive losses. All write-port outputs are registered.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-low reset (priority over rdy)
//   rdy  - global ready; 0 freezes all state and forces we=0
//   bus  - wb_arbiter_if.slave: both producer handshakes and we/waddr/wdata
module wb_arbiter #(
    parameter int LD_DEPTH   = 2,  // power of 2, >= 2
    parameter int STARVE_MAX = 3   // >= 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    wb_arbiter_if.slave   bus
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t       fifo_mem [LD_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve;
    logic            hold_v;
    wb_entry_t       hold;

    logic            force_ld;
    logic            drain_ld;
    logic            drain_alu;
    logic            alu_acc;
    logic            ld_acc;
    wb_entry_t       drain_entry;

    // Arbitration looks at registered state only, so neither ready ever
    // depends on a valid and no combinational path runs through the block.
    // NOTE: every always_comb output gets a value on every path; a missed
    // assignment would infer a latch.
    always_comb begin
        force_ld      = (count != '0) && (starve == SW'(STARVE_MAX));
        drain_ld      = (count != '0) && (!hold_v || force_ld);
        drain_alu     = hold_v && !drain_ld;
        drain_entry   = drain_ld ? fifo_mem[rd_ptr] : hold;
        bus.alu_ready = rdy && (!hold_v || drain_alu);
        // A full FIFO refuses a push even when it pops in the same edge.
        bus.ld_ready  = rdy && (count < CW'(LD_DEPTH));
        alu_acc       = bus.alu_valid && bus.alu_ready;
        ld_acc        = bus.ld_valid && bus.ld_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            hold_v    <= 1'b0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
        end else if (rdy) begin
            // x0 is never written, but its drain still updates waddr/wdata.
            bus.we <= (drain_ld || drain_alu) && (drain_entry.addr != 5'd0);
            if (drain_ld || drain_alu) begin
                bus.waddr <= drain_entry.addr;
                bus.wdata <= drain_entry.data;
            end

            if (alu_acc) begin
                hold_v <= 1'b1;
            end else if (drain_alu) begin
                hold_v <= 1'b0;
            end

            // Power-of-2 depth lets the pointers wrap naturally.
            if (ld_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drain_ld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(ld_acc) - CW'(drain_ld);

            if ((count == '0) || drain_ld) begin
                starve <= '0;
            end else if (starve != SW'(STARVE_MAX)) begin
                starve <= starve + 1'b1;
            end
        end else begin
            bus.we <= 1'b0;
        end
    end

    // NOTE: the FIFO storage and the holding payload are not reset; the
    // pointers, count and hold_v that qualify them are.
    always_ff @(posedge clk) begin
        if (alu_acc) begin
            hold <= '{addr: bus.alu_waddr, data: bus.alu_wdata};
        end
        if (ld_acc) begin
            fifo_mem[wr_ptr] <= '{addr: bus.ld_waddr, data: bus.ld_wdata};
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed testbench for wb_arbiter (LD_DEPTH=2, STARVE_MAX=3).
// Each step advances one rising edge and checks the registered write port and
// both readies 1 time unit later against hand-computed values.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.LD_DEPTH(2), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string name, input logic e_we, input logic [4:0] e_addr,
                        input logic [31:0] e_data, input logic e_ar, input logic e_lr);
        @(posedge clk);
        #1;
        check($sformatf("%s.we", name),        32'(bus.we),        32'(e_we));
        check($sformatf("%s.waddr", name),     32'(bus.waddr),     32'(e_addr));
        check($sformatf("%s.wdata", name),     bus.wdata,          e_data);
        check($sformatf("%s.alu_ready", name), 32'(bus.alu_ready), 32'(e_ar));
        check($sformatf("%s.ld_ready", name),  32'(bus.ld_ready),  32'(e_lr));
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_waddr = a;
        bus.alu_wdata = d;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_waddr = a;
        bus.ld_wdata = d;
    endtask

    initial begin
        // Reset with stimulus active: nothing may be accepted or written.
        rst = 1'b0;
        rdy = 1'b1;
        set_alu(1'b1, 5'd5, 32'h0000_1234);
        set_ld(1'b1, 5'd9, 32'h0000_0055);
        step("rst0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        step("rst1", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        rst = 1'b1;

        // Single ALU write: accepted at N, visible after N+1 for one cycle.
        set_alu(1'b1, 5'd5, 32'h0000_1234);
        step("alu_acc",  1'b0, 5'd0, 32'h0,         1'b1, 1'b1);
        set_alu(1'b0, 5'd0, 32'h0);
        step("alu_wr",   1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b1);
        step("alu_idle", 1'b0, 5'd5, 32'h0000_1234, 1'b1, 1'b1);

        // x0 result is consumed silently; the next ALU result follows at once.
        set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
        step("x0_acc",  1'b0, 5'd5, 32'h0000_1234, 1'b1, 1'b1);
        set_alu(1'b1, 5'd7, 32'h0000_0001);
        step("x0_drop", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        set_alu(1'b0, 5'd0, 32'h0);
        step("x7_wr",   1'b1, 5'd7, 32'h0000_0001, 1'b1, 1'b1);
        step("x7_idle", 1'b0, 5'd7, 32'h0000_0001, 1'b1, 1'b1);

        // Starvation: continuous ALU traffic, three back-to-back loads.
        set_alu(1'b1, 5'd17, 32'h101);
        set_ld(1'b1, 5'd1, 32'hA);
        step("sv1", 1'b0, 5'd7, 32'h1, 1'b1, 1'b1);
        set_alu(1'b1, 5'd18, 32'h102);
        set_ld(1'b1, 5'd2, 32'hB);
        step("sv2", 1'b1, 5'd17, 32'h101, 1'b1, 1'b0);
        set_alu(1'b1, 5'd19, 32'h103);
        set_ld(1'b1, 5'd3, 32'hC);
        step("sv3", 1'b1, 5'd18, 32'h102, 1'b1, 1'b0);
        set_alu(1'b1, 5'd20, 32'h104);
        step("sv4", 1'b1, 5'd19, 32'h103, 1'b0, 1'b0);
        set_alu(1'b1, 5'd21, 32'h105);
        step("sv5", 1'b1, 5'd1,  32'hA,   1'b1, 1'b1);
        step("sv6", 1'b1, 5'd20, 32'h104, 1'b1, 1'b0);
        set_alu(1'b1, 5'd22, 32'h106);
        set_ld(1'b0, 5'd0, 32'h0);
        step("sv7", 1'b1, 5'd21, 32'h105, 1'b1, 1'b0);
        set_alu(1'b1, 5'd23, 32'h107);
        step("sv8", 1'b1, 5'd22, 32'h106, 1'b0, 1'b0);
        set_alu(1'b1, 5'd24, 32'h108);
        step("sv9",  1'b1, 5'd2,  32'hB,   1'b1, 1'b1);
        step("sv10", 1'b1, 5'd23, 32'h107, 1'b1, 1'b1);
        set_alu(1'b1, 5'd25, 32'h109);
        step("sv11", 1'b1, 5'd24, 32'h108, 1'b1, 1'b1);
        set_alu(1'b1, 5'd26, 32'h10A);
        step("sv12", 1'b1, 5'd25, 32'h109, 1'b0, 1'b1);
        set_alu(1'b0, 5'd0, 32'h0);
        step("sv13", 1'b1, 5'd3,  32'hC,   1'b1, 1'b1);
        step("sv14", 1'b1, 5'd26, 32'h10A, 1'b1, 1'b1);
        step("sv15", 1'b0, 5'd26, 32'h10A, 1'b1, 1'b1);

        // rdy stall with two loads queued.
        set_alu(1'b1, 5'd30, 32'h130);
        set_ld(1'b1, 5'd11, 32'h11);
        step("st1", 1'b0, 5'd26, 32'h10A, 1'b1, 1'b1);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b1, 5'd12, 32'h22);
        step("st2", 1'b1, 5'd30, 32'h130, 1'b1, 1'b0);
        rdy = 1'b0;
        set_alu(1'b1, 5'd31, 32'h131);
        set_ld(1'b1, 5'd13, 32'h33);
        step("st3", 1'b0, 5'd30, 32'h130, 1'b0, 1'b0);
        step("st4", 1'b0, 5'd30, 32'h130, 1'b0, 1'b0);
        step("st5", 1'b0, 5'd30, 32'h130, 1'b0, 1'b0);
        rdy = 1'b1;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        step("st6", 1'b1, 5'd11, 32'h11, 1'b1, 1'b1);
        step("st7", 1'b1, 5'd12, 32'h22, 1'b1, 1'b1);
        step("st8", 1'b0, 5'd12, 32'h22, 1'b1, 1'b1);

        // Reset mid-operation: FIFO full and hold_v set, nothing may escape.
        set_alu(1'b1, 5'd10, 32'h140);
        set_ld(1'b1, 5'd14, 32'h44);
        step("mr1", 1'b0, 5'd12, 32'h22, 1'b1, 1'b1);
        set_alu(1'b1, 5'd11, 32'h141);
        set_ld(1'b1, 5'd15, 32'h55);
        step("mr2", 1'b1, 5'd10, 32'h140, 1'b1, 1'b0);
        rst = 1'b0;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        step("mr3", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        rst = 1'b1;
        step("mr4", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        step("mr5", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        step("mr6", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the register file's single write port (we/waddr/wdata) from two result producers: the single-cycle ALU path and the variable-latency load path. ALU results take priority so the execute stage never stalls; load results queue in a small FIFO, and an anti-starvation counter guarantees them a slot. All outputs are registered, so the register file sees one clean write per cycle at most. Its same-cycle read forwarding makes the write visible to decode in the cycle `we` is high.

## Interface
- LD_DEPTH, 2: load FIFO depth; a power of 2, ≥2.
- STARVE_MAX, 3: consecutive cycles a non-empty load FIFO may lose to the ALU before it is forced to win; ≥1.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global ready; when 0, the block freezes.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this edge when valid & ready.
- alu_waddr  in  5  destination register.
- alu_wdata  in  32  result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted this edge when valid & ready.
- ld_waddr  in  5  destination register.
- ld_wdata  in  32  result.
- we  out  1  register file write enable, registered.
- waddr  out  5  register file write address, registered.
- wdata  out  32  register file write data, registered.

## Operation
- State:
  - ALU holding register: hold_v, hold_addr, hold_data.
  - Load FIFO: LD_DEPTH entries, read/write pointers, count of width clog2(LD_DEPTH)+1.
  - Starvation counter: saturating, width clog2(STARVE_MAX+1).
  - Output registers for we, waddr and wdata.
- Drain select, combinational from state only:
  - force_ld = (count≠0) & (starve==STARVE_MAX).
  - drain_ld = (count≠0) & (!hold_v | force_ld).
  - drain_alu = hold_v & !drain_ld.
  - At most one source drains per cycle.
- Ready signals:
  - alu_ready = rdy & (!hold_v | drain_alu).
  - ld_ready = rdy & (count<LD_DEPTH). A push into a full FIFO is refused even while popping.
  - Neither ready depends on either valid.
- Per edge when rst=1 and rdy=1:
  - Drained entry goes to the output registers, with we=1 unless its address is 0.
  - A drained x0 entry is consumed with we=0; waddr and wdata take its values.
  - No drain: we=0; waddr and wdata hold their previous values.
  - ALU accept loads the holding register; otherwise a drain clears hold_v.
  - Load accept pushes the FIFO tail; drain_ld pops the head. Push and pop in the same edge leave count unchanged.
- Starvation counter:
  - Increments (saturating) when count≠0 & !drain_ld.
  - Clears on drain_ld or when count==0.
- rdy=0: FIFO, hold, starvation counter, waddr and wdata all hold; both readies are 0; we registers 0.
- rst=0 at an edge:
  - Clears FIFO pointers, count, hold_v, starvation counter, we, waddr and wdata.
  - Contents in flight are discarded; no write is emitted for them.
  - rst has priority over rdy.
- Ordering: FIFO order within the load source. Upstream guarantees no in-flight WAW between the two sources; the block does not check for it.

## Timing
- Reset values:
  - we=0, waddr=0, wdata=0.
  - alu_ready and ld_ready read 1 in the first cycle after release if rdy=1.
- Latency:
  - A result accepted at edge N appears on we/waddr/wdata after edge N+1 and holds for one cycle, when it wins arbitration immediately.
  - Each lost arbitration adds one cycle.
- Throughput: one write per cycle. Sustained ALU rate of 1 per cycle with alu_ready held at 1.
- Load bound: a load at the FIFO head is written within STARVE_MAX+1 cycles of reaching the head (rdy=1 throughout).
- Forced load slot: alu_ready drops for that one cycle only if hold_v=1.

## Test plan
- Reset: hold rst=0 for 2 edges with stimulus active -> we=0, waddr=0, wdata=0. After release with rdy=1: alu_ready=1, ld_ready=1.
- ALU write: accept alu x5=0x00001234 at edge N -> after N+1: we=1, waddr=5, wdata=0x00001234. After N+2: we=0.
- Starvation:
  - Stimulus: alu_valid=1 every cycle, and loads x1=0xA, x2=0xB, x3=0xC offered back-to-back; STARVE_MAX=3, LD_DEPTH=2.
  - FIFO fills at 2 and ld_ready=0.
  - After 3 ALU writes, x1=0xA is written and alu_ready=0 for that cycle. Then ld_ready=1 and x3 is accepted.
  - x2 and x3 follow, each after 3 more ALU writes.
- x0 drop: alu x0=0xFFFFFFFF -> accepted with no stall, we stays 0. A following alu x7=0x1 is written one cycle later.
- rdy stall: drop rdy for 3 cycles with 2 loads queued -> we=0 and readies 0 throughout. On rdy=1, the loads are written in original order.
- Reset mid-operation: FIFO holding 2 entries and hold_v=1, assert rst=0 for one edge -> no further writes, count=0, both readies 1 after release.
